// File: rtl/pipe_addsub_array_if.sv
// Operand/result handshake bundle for pipe_addsub_array: producer drives master, the pipe sits on slave.
interface pipe_addsub_array_if #(
  parameter int W     = 8,
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_op;
  logic [TAG_W-1:0]     in_tag;
  logic [LANES*W-1:0]   in_a;
  logic [LANES*W-1:0]   in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_y;
  logic [LANES-1:0]     out_carry;
  logic [TAG_W-1:0]     out_tag;
  logic                 busy;

  modport master (
    output in_valid, in_op, in_tag, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_carry, out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_tag, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_carry, out_tag, busy
  );
endinterface

// File: rtl/pipe_addsub_array.sv
// LANES-wide add/sub pipe, STAGES cycles accept-to-valid; a stalled output freezes every stage and drops in_ready.
// Define PIPE_ADDSUB_SATURATE_EN to clamp results on overflow/borrow instead of wrapping.
module pipe_addsub_array #(
  parameter int W      = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipe_addsub_array_if.slave bus
);

  logic                 advance;
  logic                 accept;
  logic [W:0]           lane_sum;
  logic [LANES*W-1:0]   s1_y;
  logic [LANES-1:0]     s1_c;

  logic [STAGES-1:0]    vld_q;
  logic [LANES*W-1:0]   y_q   [STAGES];
  logic [LANES-1:0]     c_q   [STAGES];
  logic [TAG_W-1:0]     tag_q [STAGES];

  assign advance = !bus.out_valid || bus.out_ready;
  assign accept  = bus.in_valid && advance;

  // W+1-bit arithmetic per lane: MSB is carry for add, borrow for sub.
  always_comb begin
    lane_sum = '0;
    s1_y     = '0;
    s1_c     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.in_op)
        lane_sum = {1'b0, bus.in_a[i*W +: W]} - {1'b0, bus.in_b[i*W +: W]};
      else
        lane_sum = {1'b0, bus.in_a[i*W +: W]} + {1'b0, bus.in_b[i*W +: W]};
      s1_c[i] = lane_sum[W];
`ifdef PIPE_ADDSUB_SATURATE_EN
      if (lane_sum[W])
        s1_y[i*W +: W] = bus.in_op ? {W{1'b0}} : {W{1'b1}};
      else
        s1_y[i*W +: W] = lane_sum[W-1:0];
`else
      s1_y[i*W +: W] = lane_sum[W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        y_q[k]   <= '0;
        c_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= accept;
      if (accept) begin
        y_q[0]   <= s1_y;
        c_q[0]   <= s1_c;
        tag_q[0] <= bus.in_tag;
      end
      // Bubbles shift through like beats so latency stays fixed.
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        y_q[k]   <= y_q[k-1];
        c_q[k]   <= c_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_y     = y_q[STAGES-1];
  assign bus.out_carry = c_q[STAGES-1];
  assign bus.out_tag   = tag_q[STAGES-1];
  assign bus.busy      = |vld_q;

endmodule

// File: tb/tb_pipe_addsub_array.sv
// Directed-vector bench for pipe_addsub_array with a queue scoreboard and an independent output monitor.
module tb_pipe_addsub_array;
  localparam int W = 8, LANES = 4, STAGES = 2, TAG_W = 4;

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  c;
    logic [3:0]  tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  pipe_addsub_array_if #(.W(W), .LANES(LANES), .TAG_W(TAG_W)) bus ();

  pipe_addsub_array #(.W(W), .LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every taken output beat is popped and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got tag 0x%0h y 0x%0h, expected no beat", bus.out_tag, bus.out_y);
        end else begin
          e = sb.pop_front();
          check("sb_tag",   {60'd0, bus.out_tag},   {60'd0, e.tag});
          check("sb_y",     {32'd0, bus.out_y},     {32'd0, e.y});
          check("sb_carry", {60'd0, bus.out_carry}, {60'd0, e.c});
        end
      end
    end
  end

  task automatic send(input logic op, input logic [3:0] tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ey, input logic [3:0] ec, input bit push);
    bit acc;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_tag   = tag;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (push) sb.push_back('{y: ey, c: ec, tag: tag});
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout: tag 0x%0h never accepted, expected accept within 50 cycles", tag);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_latency(input string name);
    for (int i = 1; i < STAGES; i++) begin
      @(negedge clk);
      check({name, "_early"}, {63'd0, bus.out_valid}, 64'd0);
      check({name, "_busy"},  {63'd0, bus.busy},      64'd1);
    end
    @(negedge clk);
    check({name, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
  endtask

  logic [31:0] sat_v1_y, sat_v2_y, sat_b1_y, sat_b3_y;

  initial begin
    checks   = 0;
    failures = 0;
`ifdef PIPE_ADDSUB_SATURATE_EN
    sat_v1_y = 32'h46FFFFFF;
    sat_v2_y = 32'h06000030;
    sat_b1_y = 32'h7F008000;
    sat_b3_y = 32'h00FF00FF;
`else
    sat_v1_y = 32'h46001000;
    sat_v2_y = 32'h06FEFF30;
    sat_b1_y = 32'h7F0080FF;
    sat_b3_y = 32'h00000000;
`endif
    // 1: reset with live input traffic
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op     = 1'b0;
    bus.in_tag    = 4'hC;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_a = $urandom();
      bus.in_b = $urandom();
      @(negedge clk);
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_busy",      {63'd0, bus.busy},      64'd0);
      check("rst_out_y",     {32'd0, bus.out_y},     64'd0);
      check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {63'd0, bus.out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;

    // 2: single add, exact latency
    send(1'b0, 4'h5, 32'h007F0110, 32'h00010222, 32'h00800332, 4'b0000, 1'b1);
    bus.in_valid = 1'b0;
    expect_latency("single_add");
    @(negedge clk);
    check("single_add_one_cycle", {63'd0, bus.out_valid}, 64'd0);
    idle(2);

    // 3 and 4: add overflow, subtract borrow
    send(1'b0, 4'h6, 32'h1280F0FF, 32'h34802001, sat_v1_y, 4'b0111, 1'b1);
    send(1'b1, 4'h7, 32'h09050050, 32'h03070120, sat_v2_y, 4'b0110, 1'b1);
    idle(5);

    // 5: back-to-back beats with a 3-cycle output stall
    fork
      begin
        send(1'b0, 4'h0, 32'h01020304, 32'h10203040, 32'h11223344, 4'b0000, 1'b1);
        send(1'b1, 4'h1, 32'h80808080, 32'h01800081, sat_b1_y,     4'b0001, 1'b1);
        send(1'b0, 4'h2, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 4'b0000, 1'b1);
        send(1'b0, 4'h3, 32'h00FF00FF, 32'h00010001, sat_b3_y,     4'b0101, 1'b1);
        bus.in_valid = 1'b0;
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
          @(posedge clk);
          #1;
          seen = bus.out_valid;
        end
        check("bp_out_valid_rose", {63'd0, seen}, 64'd1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_stall_valid",    {63'd0, bus.out_valid}, 64'd1);
          check("bp_stall_in_ready", {63'd0, bus.in_ready},  64'd0);
          check("bp_stall_tag",      {60'd0, bus.out_tag},   64'd0);
          check("bp_stall_y",        {32'd0, bus.out_y},     64'h11223344);
          check("bp_stall_carry",    {60'd0, bus.out_carry}, 64'd0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    idle(8);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // 6: reset while a beat is in flight
    send(1'b0, 4'h9, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",      {63'd0, bus.busy},      64'd0);
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_ghost", {63'd0, bus.out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    send(1'b0, 4'hA, 32'h0A0B0C0D, 32'h01010101, 32'h0B0C0D0E, 4'b0000, 1'b1);
    bus.in_valid = 1'b0;
    expect_latency("fresh_after_rst");
    idle(6);
    check("final_drained", 64'(sb.size()), 64'd0);
    check("final_idle_busy", {63'd0, bus.busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_addsub_array.md
Name: pipe_addsub_array

Overview:
- Multi-lane pipelined adder/subtractor. It generalises the single-cycle start/valid adder into a LANES-wide, STAGES-deep datapath with a valid/ready handshake, backpressure, per-lane carry/borrow and a pass-through tag.
- It sits between an operand producer and a result consumer in the datapath test designs.
- Throughput is one operation set per cycle when unstalled.

Parameters:
- W, 8: lane operand/result width in bits (>=2).
- LANES, 4: number of independent parallel lanes (>=1).
- STAGES, 2: pipeline latency in cycles from accept to out_valid (>=1).
- TAG_W, 4: width of the sideband tag carried alongside each beat (>=1).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat this cycle.
- in_op  in  1  0 = add, 1 = subtract (a - b); applies to all lanes of the beat.
- in_tag  in  TAG_W  tag echoed with the result.
- in_a  in  LANES*W  lane operands A; lane i is bits [i*W +: W].
- in_b  in  LANES*W  lane operands B, same packing.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result beat.
- out_y  out  LANES*W  lane results, same packing.
- out_carry  out  LANES  per-lane carry (add) or borrow (sub).
- out_tag  out  TAG_W  tag of the result beat.
- busy  out  1  at least one pipeline stage holds a valid beat.

Behaviour:
- Reset (async, rst_n low):
  - All stage valid bits clear: out_valid=0 and busy=0.
  - out_y=0, out_carry=0, out_tag=0.
  - In-flight beats are discarded and never emerge after reset is released.
- Advance:
  - advance = !out_valid || out_ready.
  - in_ready = advance, so in_ready=1 during and right after reset.
  - Accept = in_valid && in_ready.
  - The whole pipe shifts one stage on advance. The stage-1 valid bit loads the accept result, so a non-accepting advance inserts a bubble.
  - Bubbles are not collapsed.
- Stall:
  - When out_valid && !out_ready, every stage holds.
  - out_y, out_carry and out_tag stay bit-stable until the beat is taken.
  - Data presented with in_valid while in_ready=0 is not captured.
- Latency:
  - An accepted beat appears on out_valid exactly STAGES cycles later when there is no stall.
  - With STAGES=1, out_valid rises on the edge after accept.
- Throughput and ordering:
  - Output handshake and input accept in the same cycle are both honoured, giving 1 beat/cycle sustained.
  - Beats exit in accept order. There is no loss and no duplication.
- Arithmetic (computed in stage 1, then delayed unchanged):
  - add: {carry_i, y_i} = a_i + b_i, W+1-bit sum.
  - sub: y_i = (a_i - b_i) mod 2^W; carry_i = 1 iff a_i < b_i (unsigned borrow).
  - Lanes are fully independent; there is no inter-lane carry.
- Tag:
  - in_tag travels with its beat unchanged to out_tag.
- busy:
  - busy = OR of all stage valid bits, registered-state derived with no combinational path from inputs.
- Reset mid-operation:
  - Async clear takes effect immediately, even if a beat is stalled at the output.
  - The first accept after release behaves as from a cold start.

Optional Feature:
- Macro: PIPE_ADDSUB_SATURATE_EN.
- Defined:
  - add overflow clamps y_i to 2^W-1.
  - sub borrow clamps y_i to 0.
  - carry_i still reports the raw overflow/borrow.
  - Latency is unchanged.
- Undefined: modular wrap-around as above; no saturation logic is present.

Test Plan (W=8, LANES=4, STAGES=2, TAG_W=4):
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 and random operands -> out_valid=0, busy=0, out_y=0 throughout; no result after release.
2. Single add: lane0 a=0x10, b=0x22, tag=0x5, out_ready=1 -> exactly 2 cycles later out_valid=1 for one cycle, lane0 y=0x32, carry0=0, out_tag=0x5.
3. Add overflow: lane1 0xF0+0x20 -> y=0x10, carry1=1. With SATURATE_EN: y=0xFF, carry1=1.
4. Subtract borrow: in_op=1, lane2 0x05-0x07 -> y=0xFE, carry2=1 (SATURATE_EN: 0x00, carry2=1). Lane3 0x09-0x03 -> 0x06, carry3=0.
5. Backpressure: 4 back-to-back beats with tags 0..3, out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 while stalled, outputs bit-stable, then tags 0,1,2,3 emerge in order with correct sums; no loss or duplicates.
6. Reset mid-flight: accept tag 0x9, drop rst_n the next cycle for 2 cycles -> out_valid never asserts for tag 0x9; busy=0 immediately; a fresh beat after release has 2-cycle latency.
